mips32_fetch_unit: RTL and testbench
====================================

Name: mips32_fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the mips32 decode/execute datapath. It owns the word-indexed PC and issues one request at a time to a variable-latency instruction memory over a req/ack handshake. Returned words are buffered, with their PCs, in a small prefetch queue and presented to decode over a valid/ready handshake. It supports PC redirect with flush, and halts after a fixed instruction count.

Parameters:
WORD_W, 32, instruction and PC width
DEPTH, 4, prefetch queue entries (power of 2, >=2)
MAX_INSTR, 18, instructions delivered before halting

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-high reset
imem_req  out  1  fetch request to instruction memory
imem_addr  out  WORD_W  word address of the request (= PC)
imem_ack  in  1  memory returns imem_rdata this cycle
imem_rdata  in  WORD_W  fetched instruction word
redirect_valid  in  1  load new PC and flush
redirect_pc  in  WORD_W  redirect target
instr_valid  out  1  queue head valid toward decode
instr_ready  in  1  decode accepts head
instr  out  WORD_W  instruction at queue head
instr_pc  out  WORD_W  PC of the head instruction
halted  out  1  MAX_INSTR instructions delivered
delivered_count  out  WORD_W  count of completed decode handshakes

Behaviour:
- Reset (async, active-high): PC=0, imem_req=0, imem_addr=0, queue empty, instr_valid=0, instr=0, instr_pc=0, halted=0, delivered_count=0, drop=0, state=RUN.
- FSM states:
  - RUN: assert imem_req when occupancy+outstanding < DEPTH; on issue go to WAIT.
  - WAIT: imem_req=1; imem_addr is held stable until imem_ack.
    - On ack: push {PC, rdata} unless drop=1; PC+=1 (word index, wraps modulo 2^WORD_W); go to RUN.
    - imem_req may re-assert the cycle after ack if space remains.
  - HALT: imem_req=0, instr_valid=0, halted=1. Terminal until reset.
- imem_ack is ignored whenever imem_req=0.
- Ack-to-visible latency: a word acked in cycle N appears at the queue head no earlier than N+1.
- Delivery: a handshake occurs when instr_valid & instr_ready; it pops the head and increments delivered_count.
  - instr and instr_pc are held stable while instr_valid=1 and instr_ready=0.
- Simultaneous push and pop: occupancy unchanged, order preserved. A push into a full queue cannot occur, because requests are gated by space.
- Redirect (any state except HALT), effective next edge:
  - queue flushed; PC=redirect_pc; instr_valid=0 next cycle.
  - If in WAIT: imem_req and imem_addr stay stable until ack, the returned word is discarded (drop=1, cleared on that ack), then the next request uses redirect_pc.
  - Redirect coincident with a decode handshake: the handshake counts, and the flush still applies.
  - Redirect in HALT: ignored.
- Halt: the cycle delivered_count reaches MAX_INSTR, enter HALT.
  - Queue contents are discarded.
  - An outstanding request is completed and its data dropped.
  - imem_req is low from the cycle after ack onward.
- Reset mid-WAIT: everything returns to reset values. A late ack is ignored because imem_req=0.

Optional Feature:
- FETCH_BYPASS_EN defined: when the queue is empty, drop=0 and imem_ack=1, the word is presented the same cycle.
  - instr_valid=1, instr=imem_rdata, instr_pc=PC, combinationally.
  - If instr_ready=1 that cycle, the word is consumed and not pushed. Otherwise it is pushed normally.
- Undefined: strict registered path, minimum one-cycle ack-to-valid latency.

Decomposition:
- Shared package mips32_pkg holds:
  - WORD_W constant;
  - the fetch_state_t enum {RUN, WAIT, HALT};
  - the fetch_entry_t struct {pc, instr}.
- One sub-module, mips32_fetch_queue: synchronous FIFO of fetch_entry_t with push/pop/flush, occupancy, full/empty. It flushes on async reset and on flush.

Test Plan:
1. Reset, ack 1 cycle after each req, instr_ready=1 -> instr_pc 0,1,2,3 in order with matching instr words; delivered_count increments each cycle.
2. instr_ready=0 -> after 4 acks imem_req stays 0, occupancy 4; raise ready -> PCs 0..3 drain, then next req at imem_addr=4.
3. Redirect to 10 while the request to addr 3 is outstanding -> imem_addr holds 3 until ack; that word is never delivered; next req addr 10; first delivered instr_pc=10.
4. Ack delayed 5 cycles -> imem_req=1 and imem_addr constant for all 5 cycles; instr_valid stays 0.
5. MAX_INSTR=18, always ready -> halted=1 after the 18th handshake; imem_req low thereafter; redirect_valid pulse has no effect.
6. Assert reset mid-WAIT, then ack 2 cycles later -> all outputs at reset values; ack ignored; after release the first req addr is 0.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared types for the mips32 fetch front end: word width, fetch FSM states and
// the queue entry that carries an instruction word together with its PC.
package mips32_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        HALT
    } fetch_state_t;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [WORD_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips32_fetch_queue.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush.
// Flush (and async reset) empty the queue; flush wins over a same-cycle push/pop.
module mips32_fetch_queue
    import mips32_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  fetch_entry_t               push_data,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (occupancy == (AW+1)'(DEPTH));
    assign empty   = (occupancy == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            occupancy <= occupancy + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
        end
    end

endmodule

// File: rtl/mips32_fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, prefetch queue toward decode,
// redirect with flush, halt after MAX_INSTR deliveries. Optional macro FETCH_BYPASS_EN.
module mips32_fetch_unit
    import mips32_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int MAX_INSTR = 18
) (
    input  logic              clock,
    input  logic              reset,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [WORD_W-1:0] redirect_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] instr_pc,
    output logic              halted,
    output logic [WORD_W-1:0] delivered_count
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t       state, state_nx;
    logic [WORD_W-1:0]  pc;
    logic [WORD_W-1:0]  redir_pc_q;
    logic               drop;
    logic               halt_q;

    fetch_entry_t       q_head;
    fetch_entry_t       q_wdata;
    logic [CW-1:0]      q_occ;
    logic               q_full, q_empty;

    logic ack_ok, redir, byp, fire, halt_now, push, pop, flush;

    // Requests are only raised from WAIT, so any ack seen outside WAIT is ignored.
    assign ack_ok = (state == WAIT) && imem_ack;
    assign redir  = redirect_valid && !halt_q;

`ifdef FETCH_BYPASS_EN
    assign byp = ack_ok && !drop && !halt_q && q_empty;
`else
    assign byp = 1'b0;
`endif

    assign instr_valid = !halt_q && (!q_empty || byp);
    assign instr       = byp ? imem_rdata : q_head.instr;
    assign instr_pc    = byp ? pc         : q_head.pc;
    assign fire        = instr_valid && instr_ready;
    assign halt_now    = fire && (delivered_count == WORD_W'(MAX_INSTR - 1));

    // A word that arrives with a redirect or after halting belongs to a dead stream.
    assign flush   = redir || halt_now;
    assign pop     = fire && (q_occ != '0);
    assign push    = ack_ok && !drop && !redir && !halt_q && !(byp && instr_ready);
    assign q_wdata = '{pc: pc, instr: imem_rdata};

    assign imem_req  = (state == WAIT);
    assign imem_addr = pc;
    assign halted    = halt_q;

    mips32_fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (q_wdata),
        .pop       (pop),
        .flush     (flush),
        .head      (q_head),
        .occupancy (q_occ),
        .full      (q_full),
        .empty     (q_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= RUN;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            RUN: begin
                if (halt_q || halt_now)   state_nx = HALT;
                else if (!redir && !q_full) state_nx = WAIT;
            end
            WAIT: begin
                if (imem_ack) state_nx = (halt_q || halt_now) ? HALT : RUN;
            end
            HALT:    state_nx = HALT;
            default: state_nx = RUN;
        endcase
    end

    // While WAIT the address must stay put, so a redirect is parked until the ack.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc              <= '0;
            redir_pc_q      <= '0;
            drop            <= 1'b0;
            halt_q          <= 1'b0;
            delivered_count <= '0;
        end else begin
            if (fire)     delivered_count <= delivered_count + 1'b1;
            if (halt_now) halt_q <= 1'b1;
            if (state == WAIT) begin
                if (imem_ack) begin
                    drop <= 1'b0;
                    if (redir)     pc <= redirect_pc;
                    else if (drop) pc <= redir_pc_q;
                    else           pc <= pc + 1'b1;
                end else if (redir) begin
                    drop       <= 1'b1;
                    redir_pc_q <= redirect_pc;
                end
            end else if (redir) begin
                pc <= redirect_pc;
            end
        end
    end

endmodule

// File: tb/tb_mips32_fetch_unit.sv
// Randomized bench for mips32_fetch_unit: a latency-randomized imem responder and a
// program-order scoreboard (expected PC stream, count, halt) checked every cycle.
module tb_mips32_fetch_unit;
    import mips32_pkg::*;

    localparam int DEPTH     = 4;
    localparam int MAX_INSTR = 18;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              imem_req;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ack = 1'b0;
    logic [WORD_W-1:0] imem_rdata = '0;
    logic              redirect_valid = 1'b0;
    logic [WORD_W-1:0] redirect_pc = '0;
    logic              instr_valid;
    logic              instr_ready = 1'b0;
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] instr_pc;
    logic              halted;
    logic [WORD_W-1:0] delivered_count;

    always #5 clock = ~clock;

    mips32_fetch_unit #(.DEPTH(DEPTH), .MAX_INSTR(MAX_INSTR)) dut (
        .clock           (clock),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ack        (imem_ack),
        .imem_rdata      (imem_rdata),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc),
        .halted          (halted),
        .delivered_count (delivered_count)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // responder state and knobs
    bit          in_req;
    logic [31:0] req_addr;
    int          wait_left;
    int          n_acks;
    int          lat_min = 1, lat_max = 1, ready_pct = 100, redir_pct = 0;
    bit          force_redir;
    logic [31:0] force_target;
    bit          track_req, tracked;
    logic [31:0] tracked_addr;
    bit          track_deliv, deliv_seen;
    logic [31:0] first_deliv_pc;

    // scoreboard
    logic [31:0] exp_pc;
    int          m_count;
    bit          m_halted;
    bit          hold_pend;
    logic [31:0] hold_instr, hold_pc;

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        chk("rst_req",   32'(imem_req), 0);
        chk("rst_addr",  imem_addr, 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_pc",    instr_pc, 0);
        chk("rst_halt",  32'(halted), 0);
        chk("rst_count", delivered_count, 0);
    endtask

    task automatic model_reset();
        in_req = 0; n_acks = 0; exp_pc = 0; m_count = 0; m_halted = 0; hold_pend = 0;
        track_req = 0; tracked = 0; tracked_addr = 0;
        track_deliv = 0; deliv_seen = 0; first_deliv_pc = 0; force_redir = 0;
        redir_pct = 0;
    endtask

    task automatic do_reset();
        reset = 1; imem_ack = 0; instr_ready = 0; redirect_valid = 0; redirect_pc = 0;
        model_reset();
        repeat (2) @(negedge clock);
        #1 chk_reset();
        @(negedge clock) reset = 0;
    endtask

    task automatic step();
        @(negedge clock);
        imem_ack   = 0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!in_req) begin
                if (m_halted) chk("halt_new_req", 1, 0);
                in_req    = 1;
                req_addr  = imem_addr;
                wait_left = $urandom_range(lat_max, lat_min);
                if (track_req && !tracked) begin tracked = 1; tracked_addr = imem_addr; end
            end else begin
                chk("addr_hold", imem_addr, req_addr);
            end
            if (wait_left == 0) begin
                imem_ack = 1; imem_rdata = mem_f(req_addr); in_req = 0; n_acks++;
            end else begin
                wait_left--;
            end
        end else if (in_req) begin
            chk("req_hold", 0, 1);
            in_req = 0;
        end
        instr_ready    = ($urandom_range(99, 0) < ready_pct);
        redirect_valid = force_redir || ($urandom_range(99, 0) < redir_pct);
        redirect_pc    = force_redir ? force_target :
                         ($urandom_range(1, 0) != 0 ? 32'($urandom_range(50, 0)) : 32'hFFFFFFFD);
        force_redir    = 0;
        #1;
        chk("count",  delivered_count, m_count);
        chk("halted", 32'(halted), 32'(m_halted));
        if (m_halted) chk("halt_valid", 32'(instr_valid), 0);
        if (hold_pend) begin
            chk("hold_valid", 32'(instr_valid), 1);
            chk("hold_instr", instr, hold_instr);
            chk("hold_pc",    instr_pc, hold_pc);
        end
        hold_pend  = instr_valid && !instr_ready && !redirect_valid;
        hold_instr = instr;
        hold_pc    = instr_pc;
        if (instr_valid && instr_ready) begin
            chk("pc",    instr_pc, exp_pc);
            chk("instr", instr, mem_f(exp_pc));
            if (track_deliv && !deliv_seen) begin deliv_seen = 1; first_deliv_pc = instr_pc; end
            exp_pc++;
            m_count++;
        end
        if (redirect_valid && !m_halted) exp_pc = redirect_pc;
        if (m_count == MAX_INSTR) m_halted = 1;
    endtask

    initial begin
        model_reset();

        // in-order delivery, always ready
        do_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        repeat (20) step();
        chk("p1_progress", 32'(delivered_count >= 5), 1);

        // back-pressure fills the queue, then drains in order
        do_reset();
        ready_pct = 0;
        repeat (20) step();
        chk("fill_acks", n_acks, DEPTH);
        chk("fill_req",  32'(imem_req), 0);
        ready_pct = 100; track_req = 1;
        repeat (15) step();
        chk("drain_next_addr", tracked_addr, 4);

        // redirect while the request to addr 3 is outstanding
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 60 && !(in_req && req_addr == 3); i++) step();
        chk("redir_setup", 32'(in_req && req_addr == 3), 1);
        force_redir = 1; force_target = 10;
        step();
        track_req = 1; track_deliv = 1;
        repeat (20) step();
        chk("redir_req_addr", tracked_addr, 10);
        chk("redir_first_pc", first_deliv_pc, 10);

        // long ack latency: request and address held, nothing valid
        do_reset();
        lat_min = 5; lat_max = 5;
        for (int i = 0; i < 6; i++) begin
            step();
            if (in_req) chk("wait_valid", 32'(instr_valid), 0);
        end
        chk("wait_acks", n_acks, 1);

        // run to halt, then redirects must be ignored
        do_reset();
        lat_min = 0; lat_max = 2; ready_pct = 100;
        for (int i = 0; i < 400 && !m_halted; i++) step();
        chk("halt_reached", 32'(m_halted), 1);
        redir_pct = 50;
        repeat (12) step();
        redir_pct = 0;
        chk("halt_count", delivered_count, MAX_INSTR);
        chk("halt_req",   32'(imem_req), 0);

        // reset in the middle of WAIT, late ack ignored
        do_reset();
        lat_min = 4; lat_max = 4;
        for (int i = 0; i < 20 && !in_req; i++) step();
        step();
        reset = 1;
        #1 chk_reset();
        model_reset();
        @(negedge clock);
        @(negedge clock) begin imem_ack = 1; imem_rdata = 32'hDEADBEEF; end
        #1 chk_reset();
        @(negedge clock) reset = 0;
        lat_min = 1; lat_max = 1; ready_pct = 100; track_req = 1; track_deliv = 1;
        repeat (12) step();
        chk("post_rst_addr", tracked_addr, 0);
        chk("post_rst_pc",   first_deliv_pc, 0);

        // randomized traffic with redirects (including near PC wrap)
        for (int r = 0; r < 25; r++) begin
            do_reset();
            lat_min = 0; lat_max = 3;
            ready_pct = $urandom_range(100, 30);
            redir_pct = 5;
            repeat (80) step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
